// File: rtl/truth_table_checker_if.sv
// Sweep/check bus between truth_table_checker and its harness.
// resp_vec exists only when TRUTH_TABLE_CAPTURE_EN is defined.
interface truth_table_checker_if #(
   parameter int N_IN = 4
);
   logic              start;
   logic [N_IN-1:0]   dut_in;
   logic              dut_f;
   logic              busy;
   logic              done;
   logic              pass;
   logic [N_IN:0]     err_count;
   logic              first_fail_valid;
   logic [N_IN-1:0]   first_fail_idx;
`ifdef TRUTH_TABLE_CAPTURE_EN
   logic [2**N_IN-1:0] resp_vec;

   modport master (
      output start, dut_f,
      input  dut_in, busy, done, pass, err_count,
      input  first_fail_valid, first_fail_idx, resp_vec
   );

   modport slave (
      input  start, dut_f,
      output dut_in, busy, done, pass, err_count,
      output first_fail_valid, first_fail_idx, resp_vec
   );
`else
   modport master (
      output start, dut_f,
      input  dut_in, busy, done, pass, err_count,
      input  first_fail_valid, first_fail_idx
   );

   modport slave (
      input  start, dut_f,
      output dut_in, busy, done, pass, err_count,
      output first_fail_valid, first_fail_idx
   );
`endif
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive sweep-and-check engine for an N_IN-input, 1-output block.
// Optional macro TRUTH_TABLE_CAPTURE_EN adds the measured table resp_vec.
module truth_table_checker #(
   parameter int                  N_IN     = 4,
   parameter logic [2**N_IN-1:0]  EXPECTED = '0,
   parameter int                  DWELL    = 10
) (
   input logic                  clock,
   input logic                  reset,
   truth_table_checker_if.slave bus
);
   localparam int NV = 2**N_IN;
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [N_IN-1:0] LAST     = '1;
   localparam logic [CW-1:0]   CNT_INIT = CW'(DWELL-1);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N_IN:0]   err_q, err_d;
   logic            ffv_q, ffv_d;
   logic [N_IN-1:0] ffi_q, ffi_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            miss;
`ifdef TRUTH_TABLE_CAPTURE_EN
   logic [NV-1:0]   resp_q, resp_d;
`endif

   // Next-state and datapath updates; vec doubles as index and stimulus.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffi_d   = ffi_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
`ifdef TRUTH_TABLE_CAPTURE_EN
      resp_d  = resp_q;
`endif
      miss    = (bus.dut_f !== EXPECTED[vec_q]);
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = SETTLE;
               vec_d   = '0;
               cnt_d   = CNT_INIT;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = '0;
               ffv_d   = 1'b0;
               ffi_d   = '0;
`ifdef TRUTH_TABLE_CAPTURE_EN
               resp_d  = '0;
`endif
            end
         end
         SETTLE: begin
            if (cnt_q == '0)
               state_d = SAMPLE;
            else
               cnt_d = cnt_q - CW'(1);
         end
         SAMPLE: begin
            if (miss) begin
               err_d = err_q + (N_IN+1)'(1);
               if (!ffv_q) begin
                  ffi_d = vec_q;
                  ffv_d = 1'b1;
               end
            end
`ifdef TRUTH_TABLE_CAPTURE_EN
            resp_d[vec_q] = (bus.dut_f === 1'b1);
`endif
            // Compare before increment so dut_in never wraps.
            if (vec_q == LAST) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
               state_d = DONE;
            end else begin
               vec_d   = vec_q + N_IN'(1);
               cnt_d   = CNT_INIT;
               state_d = SETTLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset abandons any sweep.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ffv_q   <= 1'b0;
         ffi_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
`ifdef TRUTH_TABLE_CAPTURE_EN
         resp_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffi_q   <= ffi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
`ifdef TRUTH_TABLE_CAPTURE_EN
         resp_q  <= resp_d;
`endif
      end
   end

   assign bus.dut_in           = vec_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.pass             = pass_q;
   assign bus.err_count        = err_q;
   assign bus.first_fail_valid = ffv_q;
   assign bus.first_fail_idx   = ffi_q;
`ifdef TRUTH_TABLE_CAPTURE_EN
   assign bus.resp_vec         = resp_q;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: two checkers (DWELL=10 and DWELL=1) sweeping a
// modelled DUT f = EXPECTED[vec] ^ fault[vec] with random fault masks.
module tb_truth_table_checker;
   localparam logic [15:0] EXP0 = 16'hA5C3;
   localparam logic [15:0] EXP1 = 16'h3C96;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] exp0_v = EXP0;
   logic [15:0] exp1_v = EXP1;
   logic [15:0] flip0 = '0;
   logic [15:0] flip1 = '0;
   int          compared = 0;
   int          mismatched = 0;

   truth_table_checker_if #(.N_IN(4)) b0 ();
   truth_table_checker_if #(.N_IN(4)) b1 ();

   always #5 clock = ~clock;

   assign b0.dut_f = exp0_v[b0.dut_in] ^ flip0[b0.dut_in];
   assign b1.dut_f = exp1_v[b1.dut_in] ^ flip1[b1.dut_in];

   truth_table_checker #(
      .N_IN(4), .EXPECTED(EXP0), .DWELL(10)
   ) u0 (
      .clock(clock), .reset(reset), .bus(b0)
   );

   truth_table_checker #(
      .N_IN(4), .EXPECTED(EXP1), .DWELL(1)
   ) u1 (
      .clock(clock), .reset(reset), .bus(b1)
   );

   function automatic void ref_model(input logic [15:0] expv,
                                     input logic [15:0] bad,
                                     output int errs, output int first,
                                     output logic [15:0] resp);
      errs = 0;
      first = 0;
      resp = expv ^ bad;
      for (int i = 15; i >= 0; i--)
         if (bad[i]) begin
            errs++;
            first = i;
         end
   endfunction

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      compared++;
      if (b0.busy !== 0 || b0.done !== 0 || b0.pass !== 0 ||
          b0.dut_in !== 0 || b0.err_count !== 0 ||
          b0.first_fail_valid !== 0 || b0.first_fail_idx !== 0) begin
         mismatched++;
         $display("FAIL reset_u0: busy=%b done=%b pass=%b in=%0d err=%0d ffv=%b ffi=%0d, required all 0",
                  b0.busy, b0.done, b0.pass, b0.dut_in, b0.err_count,
                  b0.first_fail_valid, b0.first_fail_idx);
      end
      compared++;
      if (b1.busy !== 0 || b1.done !== 0 || b1.pass !== 0 ||
          b1.dut_in !== 0 || b1.err_count !== 0 ||
          b1.first_fail_valid !== 0 || b1.first_fail_idx !== 0) begin
         mismatched++;
         $display("FAIL reset_u1: busy=%b done=%b pass=%b in=%0d err=%0d, required all 0",
                  b1.busy, b1.done, b1.pass, b1.dut_in, b1.err_count);
      end
      reset = 1'b0;
   endtask

   task automatic sweep0(input string name, input logic [15:0] bad,
                         input int r1, input int r2);
      int errs, first, c, seqbad, want;
      logic [15:0] resp;
      flip0 = bad;
      ref_model(EXP0, bad, errs, first, resp);
      b0.start = 1'b1;
      @(posedge clock);
      #1 b0.start = 1'b0;
      compared++;
      if (b0.busy !== 1 || b0.done !== 0 || b0.pass !== 0 ||
          b0.dut_in !== 0 || b0.err_count !== 0 ||
          b0.first_fail_valid !== 0) begin
         mismatched++;
         $display("FAIL %s_entry: busy=%b done=%b pass=%b in=%0d err=%0d ffv=%b, required 1 0 0 0 0 0",
                  name, b0.busy, b0.done, b0.pass, b0.dut_in,
                  b0.err_count, b0.first_fail_valid);
      end
      c = 0;
      seqbad = 0;
      while (b0.done !== 1'b1 && c < 400) begin
         want = (c / 11 > 15) ? 15 : c / 11;
         if (b0.dut_in !== 4'(want) || b0.busy !== 1'b1) seqbad++;
         b0.start = (c == r1 || c == r2);
         @(posedge clock);
         #1;
         c++;
      end
      b0.start = 1'b0;
      compared++;
      if (c != 176) begin
         mismatched++;
         $display("FAIL %s_latency: got %0d cycles, required 176", name, c);
      end
      compared++;
      if (seqbad != 0 || b0.dut_in !== 4'd15 || b0.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL %s_stimulus: %0d bad cycles, end in=%0d busy=%b, required 0 bad, 15, 0",
                  name, seqbad, b0.dut_in, b0.busy);
      end
      compared++;
      if (b0.err_count !== 5'(errs) || b0.pass !== (errs == 0)) begin
         mismatched++;
         $display("FAIL %s_count: err=%0d pass=%b, required err=%0d pass=%b",
                  name, b0.err_count, b0.pass, errs, errs == 0);
      end
      compared++;
      if (b0.first_fail_valid !== (errs != 0) ||
          b0.first_fail_idx !== 4'(first)) begin
         mismatched++;
         $display("FAIL %s_first: ffv=%b ffi=%0d, required ffv=%b ffi=%0d",
                  name, b0.first_fail_valid, b0.first_fail_idx,
                  errs != 0, first);
      end
`ifdef TRUTH_TABLE_CAPTURE_EN
      compared++;
      if (b0.resp_vec !== resp) begin
         mismatched++;
         $display("FAIL %s_resp: got %h, required %h", name, b0.resp_vec, resp);
      end
`endif
   endtask

   task automatic test_clean_sweep;
      sweep0("clean", 16'h0000, -1, -1);
   endtask

   task automatic test_single_fault;
      sweep0("vec5", 16'h0020, -1, -1);
   endtask

   task automatic test_all_inverted;
      sweep0("inverted", 16'hFFFF, -1, -1);
   endtask

   task automatic test_random_faults;
      logic [15:0] bad;
      for (int i = 0; i < 4; i++) begin
         bad = 16'($urandom) & 16'($urandom) & 16'($urandom);
         sweep0($sformatf("rand%0d", i), bad, -1, -1);
      end
   endtask

   task automatic test_reset_mid_sweep;
      int c;
      flip0 = 16'h0006;
      b0.start = 1'b1;
      @(posedge clock);
      #1 b0.start = 1'b0;
      c = 0;
      while (b0.dut_in !== 4'd9 && c < 400) begin
         @(posedge clock);
         #1;
         c++;
      end
      compared++;
      if (c >= 400 || b0.err_count !== 5'd2) begin
         mismatched++;
         $display("FAIL midsweep_pre: in=%0d err=%0d after %0d cycles, required in=9 err=2",
                  b0.dut_in, b0.err_count, c);
      end
      reset = 1'b1;
      #1;
      compared++;
      if (b0.busy !== 0 || b0.done !== 0 || b0.pass !== 0 ||
          b0.dut_in !== 0 || b0.err_count !== 0 ||
          b0.first_fail_valid !== 0 || b0.first_fail_idx !== 0) begin
         mismatched++;
         $display("FAIL midsweep_async: busy=%b in=%0d err=%0d ffv=%b ffi=%0d, required all 0",
                  b0.busy, b0.dut_in, b0.err_count,
                  b0.first_fail_valid, b0.first_fail_idx);
      end
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      compared++;
      if (b0.busy !== 0 || b0.dut_in !== 0 || b0.done !== 0) begin
         mismatched++;
         $display("FAIL midsweep_idle: busy=%b in=%0d done=%b, required 0 0 0",
                  b0.busy, b0.dut_in, b0.done);
      end
      sweep0("after_reset", 16'h0100, -1, -1);
   endtask

   task automatic test_start_ignored;
      sweep0("restart_ign", 16'($urandom) & 16'($urandom), 20, 100);
   endtask

   task automatic test_back_to_back;
      sweep0("b2b_a", 16'h8001, -1, -1);
      sweep0("b2b_b", 16'h0000, -1, -1);
   endtask

   task automatic test_dwell1;
      int errs, first, c, seqbad, want;
      logic [15:0] resp, bad;
      for (int k = 0; k < 2; k++) begin
         bad = (k == 0) ? 16'h0000 : 16'($urandom) & 16'($urandom);
         flip1 = bad;
         ref_model(EXP1, bad, errs, first, resp);
         b1.start = 1'b1;
         @(posedge clock);
         #1 b1.start = 1'b0;
         c = 0;
         seqbad = 0;
         while (b1.done !== 1'b1 && c < 100) begin
            want = (c / 2 > 15) ? 15 : c / 2;
            if (b1.dut_in !== 4'(want)) seqbad++;
            @(posedge clock);
            #1;
            c++;
         end
         compared++;
         if (c != 32 || seqbad != 0) begin
            mismatched++;
            $display("FAIL dwell1_%0d_timing: %0d cycles %0d bad steps, required 32 cycles 0 bad",
                     k, c, seqbad);
         end
         compared++;
         if (b1.err_count !== 5'(errs) || b1.pass !== (errs == 0) ||
             b1.first_fail_valid !== (errs != 0) ||
             b1.first_fail_idx !== 4'(first)) begin
            mismatched++;
            $display("FAIL dwell1_%0d_result: err=%0d pass=%b ffv=%b ffi=%0d, required %0d %b %b %0d",
                     k, b1.err_count, b1.pass, b1.first_fail_valid,
                     b1.first_fail_idx, errs, errs == 0, errs != 0, first);
         end
`ifdef TRUTH_TABLE_CAPTURE_EN
         compared++;
         if (b1.resp_vec !== resp) begin
            mismatched++;
            $display("FAIL dwell1_%0d_resp: got %h, required %h",
                     k, b1.resp_vec, resp);
         end
`endif
      end
   endtask

   initial begin
      b0.start = 1'b0;
      b1.start = 1'b0;
      test_reset;
      test_clean_sweep;
      test_single_fault;
      test_all_inverted;
      test_random_faults;
      test_reset_mid_sweep;
      test_start_ignored;
      test_back_to_back;
      test_dwell1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule
